traffic_ctrl_n: RTL

Parametrised N-approach signalised-intersection controller. It is the next-generation replacement for our fixed 4-phase, fixed-time controller. It adds configurable approach count and phase durations, demand-actuated phase skipping, emergency preemption and a night flash mode. It sits between the sensor/request front end and the lamp drivers, and all lamp outputs use the team's {red, yellow, green} encoding: bit2 = red, bit1 = yellow, bit0 = green.

---
 rtl/traffic_pkg.sv | 32 +++
 rtl/rr_pick.sv | 29 ++
 rtl/traffic_ctrl_n.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | traffic_pkg: shared state encoding and lamp constants.             |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR   = 3'd0,
    ST_GREEN   = 3'd1,
    ST_YELLOW  = 3'd2,
    ST_PREEMPT = 3'd3,
    ST_FLASH   = 3'd4
  } state_t;

  // Lamp encoding {red, yellow, green}
  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;
  localparam logic [2:0] LIGHT_OFF = 3'b000;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_pick: round-robin selection of the next approach with demand.   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  demand,
  input  logic [PW-1:0] cur,
  output logic [PW-1:0] next
);

  logic [PW-1:0] w_idx;

  // Scan farthest-first so the nearest demanding index after cur wins;
  // cur itself (k == N) has the lowest priority.
  always_comb begin
    w_idx = '0;
    next  = (int'(cur) == N - 1) ? '0 : cur + 1'b1;
    for (int k = N; k >= 1; k--) begin
      w_idx = PW'((int'(cur) + k) % N);
      if (demand[w_idx]) next = w_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/traffic_ctrl_n.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | traffic_ctrl_n: N-approach actuated signal controller with          |
// | emergency preemption and night flash.  Revision: 1.0                |
// +--------------------------------------------------------------------+
module traffic_ctrl_n
  import traffic_pkg::*;
#(
  parameter int N        = 4,
  parameter int GREEN_T  = 7,
  parameter int YELLOW_T = 2,
  parameter int CLEAR_T  = 1,
  parameter int FLASH_T  = 4,
  localparam int PW      = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    demand,
  input  logic            preempt_req,
  input  logic [PW-1:0]   preempt_dir,
  input  logic            flash_en,
  output logic [3*N-1:0]  lights,
  output logic [PW-1:0]   phase,
  output logic            preempt_active
);

  localparam int TW = $clog2(max4(GREEN_T, YELLOW_T, CLEAR_T, FLASH_T) + 1);

  state_t        r_state;
  logic [TW-1:0] r_t;
  logic [PW-1:0] r_cur;
  logic          r_dark;

  logic [PW-1:0] w_next;
  logic [PW-1:0] w_pdir;
  logic          w_lit;
  logic [2:0]    w_col;
  logic [2:0]    w_base;

  rr_pick #(.N(N), .PW(PW)) u_rr_pick (
    .demand (demand),
    .cur    (r_cur),
    .next   (w_next)
  );

  assign w_pdir = (int'(preempt_dir) >= N) ? '0 : preempt_dir;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_CLEAR;
      r_t     <= '0;
      r_cur   <= PW'(N - 1);
      r_dark  <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_t == TW'(CLEAR_T - 1)) begin
            r_t <= '0;
            if (preempt_req) begin
              r_state <= ST_PREEMPT;
              r_cur   <= w_pdir;
            end else if (flash_en) begin
              r_state <= ST_FLASH;
              r_dark  <= 1'b0;
            end else begin
              r_state <= ST_GREEN;
              r_cur   <= w_next;
            end
          end else begin
            r_t <= r_t + 1'b1;
          end
        end
        ST_GREEN: begin
          // Preemption for the approach already green skips the yellow.
          if (preempt_req && (w_pdir == r_cur)) begin
            r_state <= ST_PREEMPT;
            r_t     <= '0;
          end else if (preempt_req || (r_t == TW'(GREEN_T - 1))) begin
            r_state <= ST_YELLOW;
            r_t     <= '0;
          end else begin
            r_t <= r_t + 1'b1;
          end
        end
        ST_YELLOW: begin
          if (r_t == TW'(YELLOW_T - 1)) begin
            r_state <= ST_CLEAR;
            r_t     <= '0;
          end else begin
            r_t <= r_t + 1'b1;
          end
        end
        ST_PREEMPT: begin
          // Hold time is unbounded, so the timer saturates here.
          if (!preempt_req) begin
            r_state <= ST_YELLOW;
            r_t     <= '0;
          end else if (r_t != '1) begin
            r_t <= r_t + 1'b1;
          end
        end
        ST_FLASH: begin
          if (preempt_req) begin
            r_state <= ST_CLEAR;
            r_t     <= '0;
          end else if (!flash_en) begin
            r_state <= ST_CLEAR;
            r_cur   <= PW'(N - 1);
            r_t     <= '0;
          end else if (r_t == TW'(FLASH_T - 1)) begin
            r_dark <= ~r_dark;
            r_t    <= '0;
          end else begin
            r_t <= r_t + 1'b1;
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_t     <= '0;
        end
      endcase
    end
  end

  always_comb begin
    w_lit  = 1'b0;
    w_col  = LIGHT_RED;
    w_base = LIGHT_RED;
    case (r_state)
      ST_GREEN, ST_PREEMPT: begin
        w_lit = 1'b1;
        w_col = LIGHT_GRN;
      end
      ST_YELLOW: begin
        w_lit = 1'b1;
        w_col = LIGHT_YEL;
      end
      ST_FLASH:  w_base = r_dark ? LIGHT_OFF : LIGHT_RED;
      default:   w_base = LIGHT_RED;
    endcase
  end

  for (genvar i = 0; i < N; i++) begin : g_lamp
    assign lights[3*i +: 3] = (w_lit && (r_cur == PW'(i))) ? w_col : w_base;
  end

  assign phase          = r_cur;
  assign preempt_active = (r_state == ST_PREEMPT);

endmodule
`default_nettype wire
